// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type, default sizing and leading-digit helper for bin_to_bcd_seq.
// Rev 1.0
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } bcd_state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DIGITS = 10;
  // Widest digit vector the helper accepts; digit_count is 4 bits, so 15 digits is the ceiling.
  localparam int MAX_DIGITS = 15;

  function automatic logic [3:0] lead_digit_count(input logic [4*MAX_DIGITS-1:0] v);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble correction, adds 3 to a BCD digit that is 5 or more.
// Rev 1.0
`default_nettype none

module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock double-dabble binary to packed BCD with significant-digit count.
// Rev 1.0
`default_nettype none

module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            digit_count
);

  localparam int CW = $clog2(WIDTH + 1);

  bcd_state_t                state;
  bcd_state_t                state_next;
  logic                      start_q;
  logic                      trig;
  logic [WIDTH-1:0]          bin_sr;
  logic [4*DIGITS-1:0]       work;
  logic [4*DIGITS-1:0]       work_adj;
  logic [4*MAX_DIGITS-1:0]   work_ext;
  logic [CW-1:0]             cnt;

  assign trig = start & ~start_q;
  assign busy = (state != IDLE);

  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_adjust
      bcd_digit_adjust u_adj (
        .din  (work[4*d +: 4]),
        .dout (work_adj[4*d +: 4])
      );
    end
  endgenerate

  always_comb begin
    work_ext                = '0;
    work_ext[4*DIGITS-1:0]  = work;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trig) state_next = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q     <= 1'b0;
      bin_sr      <= '0;
      work        <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      bcd         <= '0;
      digit_count <= 4'd0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            bin_sr <= bin;
            work   <= '0;
            cnt    <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          // Correct digits first, then shift the next binary MSB into the BCD LSB.
          work   <= {work_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
          bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt    <= cnt - CW'(1);
        end
        FINISH: begin
          bcd         <= work;
          digit_count <= lead_digit_count(work_ext);
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
